// File: rtl/dvi_clk_pkg.sv
// rtl/dvi_clk_pkg.sv - shared types and constants for the DVI pixel-clock sequencer
package dvi_clk_pkg;

    typedef enum logic [3:0] {
        ST_RESTART,
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_LOAD_D,
        ST_GAP_D,
        ST_LOAD_M,
        ST_GAP_M,
        ST_GO,
        ST_WAIT_DONE,
        ST_PLL_RST
    } state_e;

    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_LOAD_M = 2'b11;
    localparam int         FRAME_LEN  = 10;

    // Command bits occupy the low end so they go out first when shifted LSB first.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [1:0] cmd,
                                                         input logic [7:0] val);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/dcm_prog_frame.sv
// rtl/dcm_prog_frame.sv - serialises one 10-bit DCM_CLKGEN PROG frame, LSB first
module dcm_prog_frame
    import dvi_clk_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 prog_en,
    output logic                 prog_data,
    output logic                 last
);

    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 en_q, en_d;

    assign last      = en_q && (cnt_q == 4'(FRAME_LEN - 1));
    assign prog_en   = en_q;
    assign prog_data = en_q & shift_q[0];

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        if (start) begin
            shift_d = frame;
            cnt_d   = 4'd0;
            en_d    = 1'b1;
        end else if (en_q) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
            if (last) begin
                en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= 4'd0;
            en_q    <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

endmodule

// File: rtl/dvi_clkgen_sequencer.sv
// rtl/dvi_clkgen_sequencer.sv - reprograms DCM_CLKGEN M/D and restarts the PLL chain
module dvi_clkgen_sequencer
    import dvi_clk_pkg::*;
#(
    parameter int RST_PULSE = 8,
    parameter int TIMEOUT   = 1048576,
    parameter int TW        = 21
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_m_m1,
    input  logic [7:0] req_d_m1,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       dcm_locked,
    output logic       dcm_rst,
    output logic       pll_rst,
    input  logic       pll_locked,
    input  logic       bufpll_lock,
    output logic       clk_ok,
    output logic       busy,
    output logic       error
);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          dcm_rst_q, dcm_rst_d;
    logic          pll_rst_q, pll_rst_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          clk_ok_q, clk_ok_d;
    logic          error_q, error_d;
    logic          go_q, go_d;
    logic          start_q, start_d;
    logic [7:0]    m_q, m_d;
    logic [7:0]    d_q, d_d;

    logic                 all_locked;
    logic                 timeout;
    logic                 pulse_done;
    logic                 accept;
    logic                 frame_start;
    logic [FRAME_LEN-1:0] frame_word;
    logic                 frame_en;
    logic                 frame_data;
    logic                 frame_last;

    assign all_locked = dcm_locked & pll_locked & bufpll_lock;
    assign timeout    = (cnt_q == TW'(TIMEOUT));
    assign pulse_done = (cnt_q == TW'(RST_PULSE - 1));
    assign accept     = req_valid & req_ready_q;

    // The D frame starts one cycle after accept; the M frame is loaded from the gap
    // cycle so its first bit lands right after the single idle PROGEN cycle.
    assign frame_start = start_q | (state_q == ST_GAP_D);
    assign frame_word  = (state_q == ST_GAP_D) ? build_frame(CMD_LOAD_M, m_q)
                                               : build_frame(CMD_LOAD_D, d_q);

    dcm_prog_frame u_frame (
        .clk       (clkin),
        .rst_n     (reset_n),
        .start     (frame_start),
        .frame     (frame_word),
        .prog_en   (frame_en),
        .prog_data (frame_data),
        .last      (frame_last)
    );

    always_comb begin
        state_d  = state_q;
        clk_ok_d = clk_ok_q;
        error_d  = error_q;
        start_d  = 1'b0;
        m_d      = m_q;
        d_d      = d_q;

        case (state_q)
            ST_RESTART: begin
                if (pulse_done) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (all_locked) begin
                    state_d  = ST_IDLE;
                    clk_ok_d = 1'b1;
                end else if (timeout) begin
                    state_d = ST_RESTART;
                    error_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    clk_ok_d = 1'b0;
                    if (req_m_m1 == 8'd0) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        m_d     = req_m_m1;
                        d_d     = req_d_m1;
                        start_d = 1'b1;
                        state_d = ST_LOAD_D;
                    end
                end else if (!all_locked) begin
                    clk_ok_d = 1'b0;
                    state_d  = ST_RESTART;
                end else begin
                    clk_ok_d = 1'b1;
                end
            end
            ST_LOAD_D: begin
                if (frame_last) state_d = ST_GAP_D;
            end
            ST_GAP_D:  state_d = ST_LOAD_M;
            ST_LOAD_M: begin
                if (frame_last) state_d = ST_GAP_M;
            end
            ST_GAP_M:  state_d = ST_GO;
            ST_GO:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (prog_done & dcm_locked) begin
                    state_d = ST_PLL_RST;
                end else if (timeout) begin
                    state_d = ST_RESTART;
                    error_d = 1'b1;
                end
            end
            ST_PLL_RST: begin
                if (pulse_done) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_RESTART;
        endcase

        // Registered outputs are decoded from the next state so they align with it.
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        dcm_rst_d   = (state_d == ST_RESTART);
        pll_rst_d   = (state_d != ST_IDLE) && (state_d != ST_WAIT_LOCK);
        go_d        = (state_d == ST_GO);

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESTART;
            cnt_q       <= '0;
            dcm_rst_q   <= 1'b1;
            pll_rst_q   <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            clk_ok_q    <= 1'b0;
            error_q     <= 1'b0;
            go_q        <= 1'b0;
            start_q     <= 1'b0;
            m_q         <= 8'd0;
            d_q         <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcm_rst_q   <= dcm_rst_d;
            pll_rst_q   <= pll_rst_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            clk_ok_q    <= clk_ok_d;
            error_q     <= error_d;
            go_q        <= go_d;
            start_q     <= start_d;
            m_q         <= m_d;
            d_q         <= d_d;
        end
    end

    assign prog_en   = frame_en | go_q;
    assign prog_data = frame_data;
    assign dcm_rst   = dcm_rst_q;
    assign pll_rst   = pll_rst_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign clk_ok    = clk_ok_q;
    assign error     = error_q;

endmodule

// File: tb/tb_dvi_clkgen_sequencer.sv
// tb/tb_dvi_clkgen_sequencer.sv - directed self-checking bench for dvi_clkgen_sequencer
module tb_dvi_clkgen_sequencer;

    logic       clkin = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_m_m1 = 8'd0;
    logic [7:0] req_d_m1 = 8'd0;
    logic       prog_done = 1'b0;
    logic       dcm_locked = 1'b1;
    logic       pll_locked = 1'b1;
    logic       bufpll_lock = 1'b1;
    logic       req_ready, prog_en, prog_data, dcm_rst, pll_rst, clk_ok, busy, error;

    int checks = 0;
    int failures = 0;

    wire [7:0] out_vec = {dcm_rst, pll_rst, prog_en, prog_data, req_ready, busy, clk_ok, error};
    localparam logic [7:0] RESET_VEC = 8'b1100_0100;

    dvi_clkgen_sequencer #(.RST_PULSE(8), .TIMEOUT(64), .TW(21)) dut (
        .clkin       (clkin),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_m_m1    (req_m_m1),
        .req_d_m1    (req_d_m1),
        .prog_en     (prog_en),
        .prog_data   (prog_data),
        .prog_done   (prog_done),
        .dcm_locked  (dcm_locked),
        .dcm_rst     (dcm_rst),
        .pll_rst     (pll_rst),
        .pll_locked  (pll_locked),
        .bufpll_lock (bufpll_lock),
        .clk_ok      (clk_ok),
        .busy        (busy),
        .error       (error)
    );

    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] d);
        req_valid = 1'b1;
        req_m_m1  = m;
        req_d_m1  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_rst_pulse(input string tag);
        int n = 0;
        while (pll_rst && n < 50) begin
            n++;
            tick();
        end
        check_eq(tag, n, 8);
    endtask

    task automatic wait_clk_ok(input string tag, input int bound);
        int n = 0;
        while (!clk_ok && n < bound) begin
            tick();
            n++;
        end
        check_eq(tag, clk_ok, 1);
    endtask

    initial begin
        logic [22:0] en_seq;
        logic [22:0] dat_seq;
        logic        pll_all;
        int          n;

        // Reset release
        repeat (3) tick();
        check_eq("reset_vec", out_vec, RESET_VEC);
        reset_n = 1'b1;
        check_rst_pulse("reset_pll_rst_len");
        wait_clk_ok("reset_clk_ok", 10);
        check_eq("reset_ready", req_ready, 1);
        check_eq("reset_busy", busy, 0);

        // M=2, D=5 programming frame
        prog_done = 1'b0;
        send(8'd1, 8'd4);
        check_eq("acc_ready", req_ready, 0);
        check_eq("acc_clk_ok", clk_ok, 0);
        check_eq("acc_prog_en", prog_en, 0);
        check_eq("acc_pll_rst", pll_rst, 1);
        pll_all = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            en_seq[i]  = prog_en;
            dat_seq[i] = prog_data;
            pll_all    = pll_all & pll_rst;
            if (i == 5) begin
                req_valid = 1'b1;
                req_m_m1  = 8'd9;
                req_d_m1  = 8'd9;
            end else begin
                req_valid = 1'b0;
            end
        end
        check_eq("frame_en", en_seq, 23'b1_0_1111111111_0_1111111111);
        check_eq("frame_data", dat_seq, 23'b00_0000000_111_0_00000_1_0001);
        check_eq("frame_pll_rst", pll_all, 1);
        tick();
        check_eq("wd_prog_en", prog_en, 0);
        repeat (3) tick();
        check_eq("wd_pll_rst", pll_rst, 1);
        check_eq("wd_busy", busy, 1);
        prog_done = 1'b1;
        n = 0;
        while (pll_rst && n < 30) begin
            tick();
            n++;
        end
        check_eq("done_to_pll_rst_low", n, 9);
        tick();
        check_eq("prog_clk_ok", clk_ok, 1);
        check_eq("prog_ready", req_ready, 1);
        check_eq("prog_error", error, 0);
        prog_done = 1'b0;

        // Illegal M
        send(8'd0, 8'd5);
        check_eq("ill_error", error, 1);
        check_eq("ill_clk_ok_low", clk_ok, 0);
        check_eq("ill_ready", req_ready, 1);
        check_eq("ill_prog_en", prog_en, 0);
        tick();
        check_eq("ill_clk_ok_back", clk_ok, 1);
        check_eq("ill_error_sticky", error, 1);
        check_eq("ill_prog_en2", prog_en, 0);

        // prog_done timeout
        send(8'd3, 8'd2);
        check_eq("to_error_clr", error, 0);
        repeat (24) tick();
        check_eq("to_prog_en", prog_en, 0);
        n = 0;
        while (!dcm_rst && n < 200) begin
            tick();
            n++;
        end
        check_eq("to_cycles", n, 65);
        check_eq("to_error", error, 1);
        wait_clk_ok("to_recover", 30);
        check_eq("to_error_held", error, 1);

        // Lock drop in IDLE
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        check_eq("drop_clk_ok", clk_ok, 0);
        check_eq("drop_dcm_rst", dcm_rst, 1);
        check_eq("drop_pll_rst", pll_rst, 1);
        check_eq("drop_ready", req_ready, 0);
        wait_clk_ok("drop_recover", 30);

        // Reset during LOAD_M
        send(8'd2, 8'd7);
        repeat (14) tick();
        check_eq("mid_prog_en", prog_en, 1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_vec", out_vec, RESET_VEC);
        tick();
        tick();
        reset_n = 1'b1;
        check_rst_pulse("mid_pll_rst_len");
        wait_clk_ok("mid_clk_ok", 10);
        check_eq("mid_error", error, 0);
        check_eq("mid_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvi_clkgen_sequencer.md
# dvi_clkgen_sequencer

Run-time controller for the DVI pixel-clock generator. It reprograms the DCM_CLKGEN M/D ratio through its serial PROG port, which lets a new video mode change the pixel clock without reconfiguring the FPGA. It then restarts the downstream PLL_BASE and waits for the PLL and BUFPLL to lock. It sits between the video-mode register block and the DVI clock manager, and reports `clk_ok` to the TMDS encoders and serializers.

## Interface
Parameters:
- `RST_PULSE`, 8: cycles that `pll_rst`/`dcm_rst` are held high per restart (≥ 3).
- `TIMEOUT`, 1048576: maximum cycles to wait in any wait state.
- `TW`, 21: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `clkin` in 1: single clock, also fed to DCM `PROGCLK`; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a new M/D request is present.
- `req_ready` out 1: block is in IDLE and can accept a request.
- `req_m_m1` in 8: M−1; legal range 1..255 (M = 2..256).
- `req_d_m1` in 8: D−1; legal range 0..255 (D = 1..256).
- `prog_en` out 1: to DCM `PROGEN`.
- `prog_data` out 1: to DCM `PROGDATA`.
- `prog_done` in 1: from DCM `PROGDONE`.
- `dcm_locked` in 1: DCM `LOCKED`.
- `dcm_rst` out 1: DCM `RST`.
- `pll_rst` out 1: PLL_BASE `RST`.
- `pll_locked` in 1: PLL `LOCKED`.
- `bufpll_lock` in 1: BUFPLL `LOCK`.
- `clk_ok` out 1: all pixel clocks are valid.
- `busy` out 1: a sequence is in progress.
- `error` out 1: sticky; the last request was illegal or timed out. Cleared when the next request is accepted.

## Operation
States: RESTART, WAIT_LOCK, IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, PLL_RST.

- **Reset values:** state=RESTART, `dcm_rst`=1, `pll_rst`=1, `prog_en`=0, `prog_data`=0, `req_ready`=0, `busy`=1, `clk_ok`=0, `error`=0.
- **RESTART:** `dcm_rst` and `pll_rst` are high for `RST_PULSE` cycles, then the block moves to WAIT_LOCK.
- **WAIT_LOCK:**
  - Waits for `dcm_locked & pll_locked & bufpll_lock`.
  - When all three are high, moves to IDLE and sets `clk_ok`=1.
  - On timeout, sets `error`, moves to RESTART and retries indefinitely.
- **IDLE:**
  - `req_ready`=1 and `busy`=0.
  - A request is accepted on `req_valid & req_ready`. Operands are captured, `clk_ok`→0, `error`→0, and the block moves to LOAD_D.
  - If `req_m_m1`==0 at accept: set `error`, stay in IDLE, and restore `clk_ok`=1 the following cycle. No programming occurs.
  - If any of the three lock inputs drops while `clk_ok`=1: `clk_ok`→0 on the next cycle, then RESTART (auto-recovery).
- **LOAD_D:** 10 cycles with `prog_en`=1. `prog_data` sequence: 1, 0, then `d_m1[0]`..`d_m1[7]` (LSB first).
- **GAP_D:** 1 cycle with `prog_en`=0 and `prog_data`=0.
- **LOAD_M:** 10 cycles with `prog_en`=1. `prog_data` sequence: 1, 1, then `m_m1[0]`..`m_m1[7]`.
- **GAP_M:** 1 cycle with `prog_en`=0.
- **GO:** 1 cycle with `prog_en`=1 and `prog_data`=0.
- **WAIT_DONE:**
  - `pll_rst`=1 throughout.
  - Waits for `prog_done & dcm_locked`, then moves to PLL_RST.
  - On timeout: set `error`, move to RESTART.
- **PLL_RST:** `pll_rst` high for `RST_PULSE` cycles, then WAIT_LOCK.
- **`pll_rst` during programming:** asserted from LOAD_D onward, so the PLL never sees the DCM output while it is changing.
- **Timeout counter:** cleared on every state entry and saturates at `TIMEOUT`. A timeout fires when the count reaches `TIMEOUT`.
- **`reset_n` during a sequence:** the block returns asynchronously to the reset values; any partial DCM load is discarded.

## Timing
- All outputs are registered. `prog_en`/`prog_data` change on the rising edge of `clkin`, and the DCM samples them on the next rising edge.
- **Accept to first programming bit:** accept at edge N; the first `prog_en`=1 cycle starts at edge N+1.
- **Length of the programming frame:** LOAD_D through GO is 23 cycles.
- `prog_en` falls at edge N+24, and WAIT_DONE begins at the same edge.
- **Best case after programming:** 1 cycle of WAIT_DONE, then `RST_PULSE` cycles of PLL_RST, then WAIT_LOCK.
- `clk_ok` rises one cycle after the three locks are seen high in WAIT_LOCK.
- **`req_ready`:** low from the accept edge until IDLE is re-entered. `req_valid` while not ready is ignored; it is not queued.

## Structure
- **Package `dvi_clk_pkg`:**
  - state enum;
  - command constants: `CMD_LOAD_D` = 2'b01 and `CMD_LOAD_M` = 2'b11, each sent LSB first, giving the on-wire order 1,0 and 1,1;
  - `FRAME_LEN` = 10.
- **Sub-module `dcm_prog_frame`:** 10-bit shift register plus bit counter.
  - Inputs: `start` and a 10-bit frame.
  - Outputs: `prog_en`, `prog_data` and `last`.
  - The FSM uses it twice, once for D and once for M.

## Test plan
1. **Reset release:** locks tied high → `pll_rst` high for exactly 8 cycles; `clk_ok`=1 and `req_ready`=1 within 10 cycles.
2. **Request M=2, D=5 (`m_m1`=1, `d_m1`=4):**
   - `prog_data` sequence: 1,0,0,0,1,0,0,0,0,0 / gap / 1,1,1,0,0,0,0,0,0,0 / gap / GO 0.
   - 23 cycles total; `pll_rst` stays high until `prog_done`.
3. **Request with `m_m1`=0:** `error`=1, no `prog_en` pulse, `clk_ok` back to 1 next cycle.
4. **`prog_done` held low:** timeout after `TIMEOUT` cycles (bench overrides it to 64) → `error`=1, RESTART entered.
5. **`pll_locked` dropped for 1 cycle in IDLE:** `clk_ok`→0 next cycle, `pll_rst` pulse, `clk_ok` recovers once locks return.
6. **`reset_n` asserted mid-LOAD_M:** outputs at reset values immediately; a full RESTART sequence follows release.
